// File: rtl/pl_pkg.sv
// Shared types and constants for the pipeline-boundary stage.
package pl_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module pl_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pl_stage_skid.sv
// Pipeline-boundary register with valid/ready handshake, optional 2-entry skid,
// flush-to-bubble and saturating stall/flush counters.
module pl_stage_skid
   import pl_pkg::*;
#(
   parameter int unsigned          DATA_W   = 64,
   parameter logic [DATA_W-1:0]    NOP_DATA = DATA_W'(NOP_INSTR),
   parameter bit                   SKID_EN  = 1'b1,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_flush,
   input  logic              i_cnt_clr,
   input  logic              i_vld,
   output logic              o_rdy,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_vld,
   input  logic              i_rdy,
   output logic [DATA_W-1:0] o_data,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   generate
      if (SKID_EN) begin : g_skid
         skid_state_t       state_q, state_d;
         logic [DATA_W-1:0] m_q, m_d, s_q, s_d;
         logic              vld_q, rdy_q;
         logic              in_xfer, out_xfer;

         assign in_xfer  = i_vld && rdy_q;
         assign out_xfer = vld_q && i_rdy;

         // Main reg is parked at NOP_DATA whenever the stage drains or flushes.
         always_comb begin
            state_d = state_q;
            m_d     = m_q;
            s_d     = s_q;
            if (i_flush) begin
               state_d = EMPTY;
               m_d     = NOP_DATA;
               s_d     = NOP_DATA;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (in_xfer) begin
                        m_d     = i_data;
                        state_d = ONE;
                     end
                  end
                  ONE: begin
                     if (in_xfer && !out_xfer) begin
                        s_d     = i_data;
                        state_d = TWO;
                     end else if (in_xfer && out_xfer) begin
                        m_d = i_data;
                     end else if (out_xfer) begin
                        m_d     = NOP_DATA;
                        state_d = EMPTY;
                     end
                  end
                  TWO: begin
                     if (out_xfer) begin
                        m_d     = s_q;
                        s_d     = NOP_DATA;
                        state_d = ONE;
                     end
                  end
                  default: begin
                     state_d = EMPTY;
                     m_d     = NOP_DATA;
                     s_d     = NOP_DATA;
                  end
               endcase
            end
         end

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               state_q <= EMPTY;
               m_q     <= NOP_DATA;
               s_q     <= NOP_DATA;
               vld_q   <= 1'b0;
               rdy_q   <= 1'b1;
            end else begin
               state_q <= state_d;
               m_q     <= m_d;
               s_q     <= s_d;
               vld_q   <= (state_d != EMPTY);
               rdy_q   <= (state_d != TWO);
            end
         end

         assign o_rdy  = rdy_q;
         assign o_vld  = vld_q;
         assign o_data = m_q;
      end else begin : g_single
         logic [DATA_W-1:0] m_q, m_d;
         logic              vld_q, vld_d;
         logic              rdy_c, in_xfer, out_xfer;

         assign rdy_c    = !vld_q || i_rdy;
         assign in_xfer  = i_vld && rdy_c;
         assign out_xfer = vld_q && i_rdy;

         always_comb begin
            m_d   = m_q;
            vld_d = vld_q;
            if (i_flush) begin
               m_d   = NOP_DATA;
               vld_d = 1'b0;
            end else if (in_xfer) begin
               m_d   = i_data;
               vld_d = 1'b1;
            end else if (out_xfer) begin
               m_d   = NOP_DATA;
               vld_d = 1'b0;
            end
         end

         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               m_q   <= NOP_DATA;
               vld_q <= 1'b0;
            end else begin
               m_q   <= m_d;
               vld_q <= vld_d;
            end
         end

         assign o_rdy  = rdy_c;
         assign o_vld  = vld_q;
         assign o_data = m_q;
      end
   endgenerate

   logic stall_inc, flush_inc;

   assign stall_inc = o_vld && !i_rdy && !i_flush;
   assign flush_inc = i_flush && o_vld;

   pl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .inc     (stall_inc),
      .clr     (i_cnt_clr),
      .cnt     (o_stall_cnt)
   );

   pl_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .inc     (flush_inc),
      .clr     (i_cnt_clr),
      .cnt     (o_flush_cnt)
   );

endmodule

// File: tb/tb_pl_stage_skid.sv
// Scoreboard bench driving a skid instance and a single-register instance with shared stimulus.
module tb_pl_stage_skid;

   typedef logic [63:0] beat_t;
   localparam beat_t NOP = 64'h0000_0000_0000_0013;

   logic  clk = 1'b0;
   logic  i_reset = 1'b1;
   logic  i_flush = 1'b0, i_cnt_clr = 1'b0, i_vld = 1'b0, i_rdy = 1'b1;
   beat_t i_data = '0;

   logic       rdy0, vld0, rdy1, vld1;
   beat_t      dat0, dat1;
   logic [3:0] sc0, fc0, sc1, fc1;

   int n_total = 0;
   int n_bad   = 0;

   beat_t      sbq0[$];
   beat_t      sbq1[$];
   logic [3:0] exp_stall [2];
   logic [3:0] exp_flush [2];

   always #5 clk = ~clk;

   pl_stage_skid #(.DATA_W(64), .SKID_EN(1'b1), .CNT_W(4)) u_skid (
      .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_cnt_clr(i_cnt_clr),
      .i_vld(i_vld), .o_rdy(rdy0), .i_data(i_data), .o_vld(vld0), .i_rdy(i_rdy),
      .o_data(dat0), .o_stall_cnt(sc0), .o_flush_cnt(fc0)
   );

   pl_stage_skid #(.DATA_W(64), .SKID_EN(1'b0), .CNT_W(4)) u_single (
      .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_cnt_clr(i_cnt_clr),
      .i_vld(i_vld), .o_rdy(rdy1), .i_data(i_data), .o_vld(vld1), .i_rdy(i_rdy),
      .o_data(dat1), .o_stall_cnt(sc1), .o_flush_cnt(fc1)
   );

   task automatic chk(input string tag, input beat_t got, input beat_t exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Compare one instance against its model, then advance the model for the coming edge.
   task automatic eval(input int k);
      beat_t      q[$];
      logic       vo, ro, exp_vld, exp_rdy, inx, outx;
      beat_t      dout, exp_d;
      logic [3:0] sc, fc;
      if (k == 0) begin
         q = sbq0; vo = vld0; ro = rdy0; dout = dat0; sc = sc0; fc = fc0;
      end else begin
         q = sbq1; vo = vld1; ro = rdy1; dout = dat1; sc = sc1; fc = fc1;
      end
      chk($sformatf("stall_cnt%0d", k), 64'(sc), 64'(exp_stall[k]));
      chk($sformatf("flush_cnt%0d", k), 64'(fc), 64'(exp_flush[k]));
      exp_vld = (q.size() != 0);
      exp_rdy = (k == 0) ? (q.size() < 2) : (!exp_vld || i_rdy);
      exp_d   = exp_vld ? q[0] : NOP;
      chk($sformatf("vld%0d", k), 64'(vo), 64'(exp_vld));
      chk($sformatf("rdy%0d", k), 64'(ro), 64'(exp_rdy));
      chk($sformatf("data%0d", k), dout, exp_d);
      inx  = i_vld && exp_rdy;
      outx = exp_vld && i_rdy;
      if (i_cnt_clr) begin
         exp_stall[k] = '0;
         exp_flush[k] = '0;
      end else begin
         if (exp_vld && !i_rdy && !i_flush && exp_stall[k] != 4'hF) exp_stall[k] = exp_stall[k] + 4'd1;
         if (i_flush && exp_vld && exp_flush[k] != 4'hF) exp_flush[k] = exp_flush[k] + 4'd1;
      end
      if (i_flush) begin
         q.delete();
      end else begin
         if (outx) void'(q.pop_front());
         if (inx) q.push_back(i_data);
      end
      if (k == 0) sbq0 = q; else sbq1 = q;
   endtask

   task automatic cyc(input logic v, input beat_t d, input logic r, input logic f, input logic c);
      @(negedge clk);
      i_vld = v; i_data = d; i_rdy = r; i_flush = f; i_cnt_clr = c;
      #1;
      eval(0);
      eval(1);
   endtask

   // Asynchronous reset: outputs must return to reset values with no clock edge.
   task automatic do_reset();
      i_vld = 1'b0; i_flush = 1'b0; i_cnt_clr = 1'b0; i_rdy = 1'b1; i_data = '0;
      i_reset = 1'b0;
      #1;
      chk("rst_vld0", 64'(vld0), 64'd0);
      chk("rst_data0", dat0, NOP);
      chk("rst_rdy0", 64'(rdy0), 64'd1);
      chk("rst_cnt0", 64'({sc0, fc0}), 64'd0);
      chk("rst_vld1", 64'(vld1), 64'd0);
      chk("rst_data1", dat1, NOP);
      chk("rst_rdy1", 64'(rdy1), 64'd1);
      chk("rst_cnt1", 64'({sc1, fc1}), 64'd0);
      sbq0.delete();
      sbq1.delete();
      for (int k = 0; k < 2; k++) begin
         exp_stall[k] = '0;
         exp_flush[k] = '0;
      end
      repeat (3) @(negedge clk);
      i_reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // Streaming at full rate
      for (int i = 1; i <= 8; i++) cyc(1'b1, 64'h1000_0000_0000_0000 + beat_t'(i), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Skid fill with C held off, then release
      cyc(1'b1, 64'hAAAA_0000_0000_000A, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hBBBB_0000_0000_000B, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 64'hCCCC_0000_0000_000C, 1'b0, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 64'hCCCC_0000_0000_000C, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush while full with a beat offered in the same cycle
      cyc(1'b1, 64'hEEEE_0000_0000_000E, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hFFFF_0000_0000_000F, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'hDDDD_0000_0000_000D, 1'b0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Counter saturation, then clear racing a stall
      cyc(1'b1, 64'h6666_0000_0000_0006, 1'b0, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Reset asserted mid-stall, then recovery
      cyc(1'b1, 64'h7777_0000_0000_0007, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 64'h8888_0000_0000_0008, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 64'h9000_0000_0000_0000 + beat_t'(i), (i != 1), 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
